// File: rtl/wb_master_arbiter_pkg.sv
// Shared Wishbone widths, arbiter FSM states and watchdog sizing helper.
package wb_master_arbiter_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_ERR     = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // Watchdog counter width; a disabled watchdog still gets one (unused) bit.
  function automatic int wd_width(input int timeout_cyc);
    return (timeout_cyc > 0) ? $clog2(timeout_cyc + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_master_arbiter_rr_picker.sv
// Round-robin picker: first requester strictly after the pointer, wrapping.
module wb_master_arbiter_rr_picker #(
  parameter int N     = 2,
  parameter int PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan N slots starting one past the pointer; the pointer's own slot is last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = PTR_W'((int'(ptr) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone master arbiter with per-transfer stall watchdog.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int NUM_MASTER  = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_MASTER-1:0]       i_wbm_cyc,
  input  logic [NUM_MASTER-1:0]       i_wbm_stb,
  input  logic [NUM_MASTER-1:0]       i_wbm_we,
  input  logic [WB_AW*NUM_MASTER-1:0] i_wbm_addr,
  input  logic [WB_DW*NUM_MASTER-1:0] i_wbm_data,
  output logic [WB_DW-1:0]            o_wbm_data,
  output logic [NUM_MASTER-1:0]       o_wbm_ack,
  output logic [NUM_MASTER-1:0]       o_wbm_err,
  output logic                        o_wb_cyc,
  output logic                        o_wb_stb,
  output logic                        o_wb_we,
  output logic [WB_AW-1:0]            o_wb_addr,
  output logic [WB_DW-1:0]            o_wb_data,
  input  logic [WB_DW-1:0]            i_wb_data,
  input  logic                        i_wb_ack,
  output logic [NUM_MASTER-1:0]       o_grant
);

  localparam int PTR_W = $clog2(NUM_MASTER);
  localparam int WD_W  = wd_width(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYC);

  arb_state_t              state_reg;
  logic [NUM_MASTER-1:0]   grant_reg;
  logic [PTR_W-1:0]        gidx_reg;
  logic [PTR_W-1:0]        ptr_reg;
  logic [WD_W-1:0]         wd_reg;

  logic [NUM_MASTER-1:0]   pick;
  logic [PTR_W-1:0]        pick_idx;
  logic [WB_AW-1:0]        addr_arr [NUM_MASTER];
  logic [WB_DW-1:0]        data_arr [NUM_MASTER];

  logic in_grant;
  logic g_cyc;
  logic g_stb;
  logic g_we;
  logic fwd_ack;
  logic wd_hit;

  for (genvar gi = 0; gi < NUM_MASTER; gi++) begin : g_unpack
    assign addr_arr[gi] = i_wbm_addr[WB_AW*gi +: WB_AW];
    assign data_arr[gi] = i_wbm_data[WB_DW*gi +: WB_DW];
  end

  wb_master_arbiter_rr_picker #(
    .N     (NUM_MASTER),
    .PTR_W (PTR_W)
  ) u_picker (
    .req       (i_wbm_cyc),
    .ptr       (ptr_reg),
    .grant     (pick),
    .grant_idx (pick_idx)
  );

  assign in_grant = (state_reg == ST_GRANT);
  assign g_cyc    = i_wbm_cyc[gidx_reg];
  assign g_stb    = i_wbm_stb[gidx_reg];
  assign g_we     = i_wbm_we[gidx_reg];
  // Ack in the cycle cyc drops belongs to no transfer, so it is dropped.
  assign fwd_ack  = in_grant & g_cyc & g_stb & i_wb_ack;
  // Terminal count is reached this cycle only if the slave still has not acked.
  assign wd_hit   = (TIMEOUT_CYC != 0) && in_grant && g_cyc && g_stb && !i_wb_ack &&
                    ((32'(wd_reg) + 32'd1) == 32'(TIMEOUT_CYC));

  // Downstream port follows the owner only while the transfer is live.
  assign o_wb_cyc   = in_grant & g_cyc;
  assign o_wb_stb   = in_grant & g_cyc & g_stb;
  assign o_wb_we    = in_grant & g_we;
  assign o_wb_addr  = in_grant ? addr_arr[gidx_reg] : '0;
  assign o_wb_data  = in_grant ? data_arr[gidx_reg] : '0;
  assign o_wbm_data = in_grant ? i_wb_data : '0;
  assign o_wbm_ack  = fwd_ack ? grant_reg : '0;
  assign o_wbm_err  = (state_reg == ST_ERR) ? grant_reg : '0;
  assign o_grant    = grant_reg;

  // Arbitration FSM, grant/pointer registers and stall watchdog.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      grant_reg <= '0;
      gidx_reg  <= '0;
      ptr_reg   <= PTR_W'(NUM_MASTER - 1);
      wd_reg    <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          wd_reg <= '0;
          if (|i_wbm_cyc) begin
            grant_reg <= pick;
            gidx_reg  <= pick_idx;
            state_reg <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!g_cyc) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            ptr_reg   <= gidx_reg;
            wd_reg    <= '0;
          end else if (wd_hit) begin
            state_reg <= ST_ERR;
            wd_reg    <= wd_reg + WD_W'(1);
          end else if (!g_stb || i_wb_ack) begin
            wd_reg <= '0;
          end else if ((TIMEOUT_CYC != 0) && (wd_reg != WD_MAX)) begin
            wd_reg <= wd_reg + WD_W'(1);
          end
        end
        ST_ERR: begin
          state_reg <= ST_RELEASE;
          wd_reg    <= '0;
        end
        ST_RELEASE: begin
          if (!g_cyc) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            ptr_reg   <= gidx_reg;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Bench for wb_master_arbiter: behavioural ownership model plus directed cases.
module tb_wb_master_arbiter;

  localparam int NM = 2;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NM-1:0] wbm_cyc = '0;
  logic [NM-1:0] wbm_stb = '0;
  logic [NM-1:0] wbm_we  = '0;
  logic [63:0]   wbm_addr = '0;
  logic [63:0]   wbm_data = '0;
  logic [31:0]   wb_data_in = '0;
  logic          wb_ack = 1'b0;

  logic [31:0]   d_wbm_data, z_wbm_data;
  logic [NM-1:0] d_wbm_ack, d_wbm_err, d_grant, z_wbm_ack, z_wbm_err, z_grant;
  logic          d_wb_cyc, d_wb_stb, d_wb_we, z_wb_cyc, z_wb_stb, z_wb_we;
  logic [31:0]   d_wb_addr, d_wb_data, z_wb_addr, z_wb_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_master_arbiter #(.NUM_MASTER(NM), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .i_wbm_cyc(wbm_cyc), .i_wbm_stb(wbm_stb), .i_wbm_we(wbm_we),
    .i_wbm_addr(wbm_addr), .i_wbm_data(wbm_data),
    .o_wbm_data(d_wbm_data), .o_wbm_ack(d_wbm_ack), .o_wbm_err(d_wbm_err),
    .o_wb_cyc(d_wb_cyc), .o_wb_stb(d_wb_stb), .o_wb_we(d_wb_we),
    .o_wb_addr(d_wb_addr), .o_wb_data(d_wb_data),
    .i_wb_data(wb_data_in), .i_wb_ack(wb_ack), .o_grant(d_grant)
  );

  // Same stimulus, watchdog disabled.
  wb_master_arbiter #(.NUM_MASTER(NM), .TIMEOUT_CYC(0)) dut_nowd (
    .clk(clk), .rst(rst),
    .i_wbm_cyc(wbm_cyc), .i_wbm_stb(wbm_stb), .i_wbm_we(wbm_we),
    .i_wbm_addr(wbm_addr), .i_wbm_data(wbm_data),
    .o_wbm_data(z_wbm_data), .o_wbm_ack(z_wbm_ack), .o_wbm_err(z_wbm_err),
    .o_wb_cyc(z_wb_cyc), .o_wb_stb(z_wb_stb), .o_wb_we(z_wb_we),
    .o_wb_addr(z_wb_addr), .o_wb_data(z_wb_data),
    .i_wb_data(wb_data_in), .i_wb_ack(wb_ack), .o_grant(z_grant)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic bit_at(input logic [NM-1:0] v, input int i);
    logic [NM-1:0] s;
    s = v >> i;
    return s[0];
  endfunction

  // Model: who owns the bus, whether its transfer is live / erroring / draining,
  // how long its strobe has gone unanswered, and who owned it last.
  int m_owner = -1;
  int m_phase = 0;   // 0 live, 1 error cycle, 2 waiting for cyc drop
  int m_stall = 0;
  int m_last  = NM - 1;

  task automatic model_reset();
    m_owner = -1; m_phase = 0; m_stall = 0; m_last = NM - 1;
  endtask

  task automatic model_step();
    int c;
    if (m_owner < 0) begin
      for (int k = 1; k <= NM; k++) begin
        c = (m_last + k) % NM;
        if (m_owner < 0 && bit_at(wbm_cyc, c)) m_owner = c;
      end
      m_phase = 0;
      m_stall = 0;
    end else if (m_phase == 0) begin
      if (!bit_at(wbm_cyc, m_owner)) begin
        m_last = m_owner; m_owner = -1;
      end else if (bit_at(wbm_stb, m_owner) && !wb_ack) begin
        m_stall++;
        if (m_stall == TO) m_phase = 1;
      end else begin
        m_stall = 0;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (!bit_at(wbm_cyc, m_owner)) begin
      m_last = m_owner; m_owner = -1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  task automatic compare_now();
    logic [NM-1:0] eg, eack, eerr;
    logic ecyc, estb, ewe, busy, gc, gs, gw;
    logic [31:0] ea, ed, erd;
    eg = '0; eack = '0; eerr = '0; ecyc = 0; estb = 0; ewe = 0;
    ea = '0; ed = '0; erd = '0;
    if (!rst && m_owner >= 0) begin
      eg   = NM'(1 << m_owner);
      busy = (m_phase == 0);
      gc   = bit_at(wbm_cyc, m_owner);
      gs   = bit_at(wbm_stb, m_owner);
      gw   = bit_at(wbm_we, m_owner);
      ecyc = busy & gc;
      estb = busy & gc & gs;
      ewe  = busy & gw;
      ea   = busy ? 32'(wbm_addr >> (32 * m_owner)) : 32'h0;
      ed   = busy ? 32'(wbm_data >> (32 * m_owner)) : 32'h0;
      erd  = busy ? wb_data_in : 32'h0;
      eack = (busy & gc & gs & wb_ack) ? eg : '0;
      eerr = (m_phase == 1) ? eg : '0;
    end
    chk("grant",    32'(d_grant),   32'(eg));
    chk("wbm_ack",  32'(d_wbm_ack), 32'(eack));
    chk("wbm_err",  32'(d_wbm_err), 32'(eerr));
    chk("wb_cyc",   32'(d_wb_cyc),  32'(ecyc));
    chk("wb_stb",   32'(d_wb_stb),  32'(estb));
    chk("wb_we",    32'(d_wb_we),   32'(ewe));
    chk("wb_addr",  d_wb_addr,      ea);
    chk("wb_data",  d_wb_data,      ed);
    chk("wbm_data", d_wbm_data,     erd);
    chk("nowd_err", 32'(z_wbm_err), 32'h0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      compare_now();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_m(input int k, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [31:0] d);
    wbm_cyc[k] = c;
    wbm_stb[k] = s;
    wbm_we[k]  = w;
    wbm_addr[32*k +: 32] = a;
    wbm_data[32*k +: 32] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wbm_cyc = '0; wbm_stb = '0; wbm_we = '0; wbm_addr = '0; wbm_data = '0;
    wb_ack = 1'b0; wb_data_in = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
  endtask

  logic [NM-1:0] exp_seq [4];
  int g;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_seq[0] = 2'b01; exp_seq[1] = 2'b10; exp_seq[2] = 2'b01; exp_seq[3] = 2'b10;

    // Reset state
    rst = 1'b1;
    #2;
    chk("rst_grant", 32'(d_grant), 32'h0);
    chk("rst_cyc", 32'(d_wb_cyc), 32'h0);
    do_reset();

    // 1: M0 single write, ack on third stb cycle
    step();
    set_m(0, 1, 1, 1, 32'h0000_0104, 32'h1122_3344);
    mid();
    chk("t1_latency_grant", 32'(d_grant), 32'h0);
    chk("t1_latency_cyc", 32'(d_wb_cyc), 32'h0);
    step();
    mid();
    chk("t1_grant", 32'(d_grant), 32'h1);
    chk("t1_addr", d_wb_addr, 32'h0000_0104);
    chk("t1_wdata", d_wb_data, 32'h1122_3344);
    step();
    step();
    wb_ack = 1'b1;
    mid();
    chk("t1_ack", 32'(d_wbm_ack), 32'h1);
    step();
    wb_ack = 1'b0;
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    mid();
    chk("t1_ack_gone", 32'(d_wbm_ack), 32'h0);
    step();
    mid();
    chk("t1_release", 32'(d_grant), 32'h0);
    $display("TXN t1 m0 write addr=00000104 acked");

    // 2: both masters contend continuously, grants must alternate
    do_reset();
    step();
    set_m(0, 1, 1, 0, 32'h0000_0010, 32'h0);
    set_m(1, 1, 1, 0, 32'h0000_0020, 32'h0);
    step();
    for (int r = 0; r < 4; r++) begin
      mid();
      chk("t2_grant_seq", 32'(d_grant), 32'(exp_seq[r]));
      $display("TXN t2 round %0d grant=%b", r, d_grant);
      g = (d_grant == 2'b10) ? 1 : 0;
      wb_ack = 1'b1;
      step();
      wb_ack = 1'b0;
      wbm_cyc[g] = 1'b0;
      wbm_stb[g] = 1'b0;
      step();
      wbm_cyc[g] = 1'b1;
      wbm_stb[g] = 1'b1;
      mid();
      chk("t2_idle_gap", 32'(d_grant), 32'h0);
      step();
    end

    // 3: M1 read returning 0xDEADBEEF
    do_reset();
    step();
    set_m(1, 1, 1, 0, 32'h0000_0200, 32'h0);
    step();
    mid();
    chk("t3_grant", 32'(d_grant), 32'h2);
    step();
    wb_data_in = 32'hDEAD_BEEF;
    wb_ack = 1'b1;
    mid();
    chk("t3_rdata", d_wbm_data, 32'hDEAD_BEEF);
    chk("t3_ack", 32'(d_wbm_ack), 32'h2);
    step();
    wb_ack = 1'b0;
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();
    $display("TXN t3 m1 read data=deadbeef");

    // 4: slave never acks; watchdog error then M1 takes over
    do_reset();
    step();
    set_m(0, 1, 1, 1, 32'h0000_0400, 32'hCAFE_0000);
    set_m(1, 1, 1, 0, 32'h0000_0500, 32'h0);
    step();
    for (int k = 1; k <= 4; k++) begin
      mid();
      chk("t4_no_err_yet", 32'(d_wbm_err), 32'h0);
      chk("t4_cyc_live", 32'(d_wb_cyc), 32'h1);
      step();
    end
    mid();
    chk("t4_err_pulse", 32'(d_wbm_err), 32'h1);
    chk("t4_cyc_forced", 32'(d_wb_cyc), 32'h0);
    chk("t4_nowd_cyc", 32'(z_wb_cyc), 32'h1);
    step();
    mid();
    chk("t4_err_once", 32'(d_wbm_err), 32'h0);
    chk("t4_grant_held", 32'(d_grant), 32'h1);
    step();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    mid();
    chk("t4_grant_held2", 32'(d_grant), 32'h1);
    step();
    mid();
    chk("t4_idle", 32'(d_grant), 32'h0);
    step();
    mid();
    chk("t4_m1_granted", 32'(d_grant), 32'h2);
    $display("TXN t4 m0 timeout err, m1 granted");
    step();
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();

    // 5: ack on the terminal cycle wins over the watchdog
    do_reset();
    step();
    set_m(0, 1, 1, 0, 32'h0000_0300, 32'h0);
    step();
    for (int k = 1; k <= 3; k++) begin
      mid();
      chk("t5_no_err", 32'(d_wbm_err), 32'h0);
      step();
    end
    wb_ack = 1'b1;
    wb_data_in = 32'h0000_5A5A;
    mid();
    chk("t5_term_ack", 32'(d_wbm_ack), 32'h1);
    chk("t5_term_no_err", 32'(d_wbm_err), 32'h0);
    step();
    wb_ack = 1'b0;
    mid();
    chk("t5_after_no_err", 32'(d_wbm_err), 32'h0);
    chk("t5_after_cyc", 32'(d_wb_cyc), 32'h1);
    step();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();
    $display("TXN t5 m0 ack on terminal cycle");

    // 6: asynchronous reset mid-burst, then master 0 first again
    do_reset();
    step();
    set_m(0, 1, 1, 0, 32'h0000_0600, 32'h0);
    step();
    step();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    step();
    set_m(0, 1, 1, 0, 32'h0000_0600, 32'h0);
    set_m(1, 1, 1, 1, 32'h0000_0700, 32'h7777_7777);
    step();
    mid();
    chk("t6_m1_burst", 32'(d_grant), 32'h2);
    #2;
    rst = 1'b1;
    wb_ack = 1'b1;
    #1;
    chk("t6_async_grant", 32'(d_grant), 32'h0);
    chk("t6_async_cyc", 32'(d_wb_cyc), 32'h0);
    chk("t6_async_addr", d_wb_addr, 32'h0);
    chk("t6_async_ack", 32'(d_wbm_ack), 32'h0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    wb_ack = 1'b0;
    step();
    mid();
    chk("t6_regrant_m0", 32'(d_grant), 32'h1);
    $display("TXN t6 reset mid-burst, m0 regranted");
    step();
    set_m(0, 0, 0, 0, 32'h0, 32'h0);
    set_m(1, 0, 0, 0, 32'h0, 32'h0);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
